// File: rtl/alu_issue_capture_if.sv
// Issue (upstream) and result (downstream) valid/ready handshakes of alu_issue_capture.
// The block itself connects through the slave modport; its producer/consumer uses master.
interface alu_issue_capture_if #(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_opcode;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [SHIFT_W-1:0] in_shift;

  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;
  logic               out_carry;
  logic               out_zero;
  logic               out_overflow;
  logic               out_illegal;

  modport master (
    output in_valid, in_opcode, in_a, in_b, in_shift, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero, out_overflow, out_illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_shift, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero, out_overflow, out_illegal
  );
endinterface

// File: rtl/alu_issue_capture.sv
// Two-stage issue/capture pipeline around an external combinational ALU, with
// opcode legality checking and completion / illegal-packet counters.
module alu_issue_capture #(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 5,
  parameter int MAX_OP  = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  alu_issue_capture_if.slave bus,
  output logic [3:0]         alu_opcode,
  output logic [WIDTH-1:0]   alu_input1,
  output logic [WIDTH-1:0]   alu_input2,
  output logic [SHIFT_W-1:0] alu_shiftValue,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carry,
  input  logic               alu_zero,
  input  logic               alu_overflow,
  output logic [CNT_W-1:0]   op_count,
  output logic [7:0]         illegal_count
);
  localparam logic [3:0] MAX_OP_L = 4'(MAX_OP);

  logic s1_valid;
  logic s1_illegal;
  logic s2_take;
  logic s1_adv;
  logic accept;
  logic complete;

  // Ready looks through both stages combinationally so a full pipe still takes
  // one packet per cycle while the consumer is accepting.
  assign s2_take      = !bus.out_valid || bus.out_ready;
  assign s1_adv       = s1_valid && s2_take;
  assign bus.in_ready = !rst && !flush && (!s1_valid || s1_adv);
  assign accept       = bus.in_valid && bus.in_ready;
  assign complete     = bus.out_valid && bus.out_ready;

  // NOTE: every register here is updated with <= so all stages see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid         <= 1'b0;
      s1_illegal       <= 1'b0;
      alu_opcode       <= '0;
      alu_input1       <= '0;
      alu_input2       <= '0;
      alu_shiftValue   <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_result   <= '0;
      bus.out_carry    <= 1'b0;
      bus.out_zero     <= 1'b0;
      bus.out_overflow <= 1'b0;
      bus.out_illegal  <= 1'b0;
      op_count         <= '0;
      illegal_count    <= '0;
    end else begin
      // Issue stage: the raw opcode reaches the ALU even when it is illegal.
      if (accept) begin
        s1_valid       <= 1'b1;
        s1_illegal     <= (bus.in_opcode > MAX_OP_L);
        alu_opcode     <= bus.in_opcode;
        alu_input1     <= bus.in_a;
        alu_input2     <= bus.in_b;
        alu_shiftValue <= bus.in_shift;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      // Capture stage: a flush drops the hand-off, so the data registers keep their contents.
      if (s1_adv && !flush) begin
        bus.out_valid   <= 1'b1;
        bus.out_illegal <= s1_illegal;
        if (s1_illegal) begin
          bus.out_result   <= '0;
          bus.out_carry    <= 1'b0;
          bus.out_zero     <= 1'b0;
          bus.out_overflow <= 1'b0;
        end else begin
          bus.out_result   <= alu_result;
          bus.out_carry    <= alu_carry;
          bus.out_zero     <= alu_zero;
          bus.out_overflow <= alu_overflow;
        end
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (flush) begin
        s1_valid      <= 1'b0;
        bus.out_valid <= 1'b0;
      end

      // A handshake completing alongside a flush is still counted.
      if (complete) begin
        op_count <= op_count + CNT_W'(1);
        if (bus.out_illegal && (illegal_count != 8'hFF)) begin
          illegal_count <= illegal_count + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_capture.sv
// Self-checking bench for alu_issue_capture: a behavioural ALU stub closes the loop and
// an in-flight queue model predicts handshakes, output packets and counters every cycle.
module tb_alu_issue_capture;
  localparam int WIDTH   = 8;
  localparam int SHIFT_W = 5;
  localparam int MAX_OP  = 5;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic [3:0]         alu_opcode;
  logic [WIDTH-1:0]   alu_input1;
  logic [WIDTH-1:0]   alu_input2;
  logic [SHIFT_W-1:0] alu_shiftValue;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_carry;
  logic               alu_zero;
  logic               alu_overflow;
  logic [CNT_W-1:0]   op_count;
  logic [7:0]         illegal_count;

  alu_issue_capture_if #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) bus ();

  alu_issue_capture #(
    .WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .MAX_OP(MAX_OP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shiftValue(alu_shiftValue), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .op_count(op_count), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ill;
    logic       c;
    logic       z;
    logic       v;
    logic [7:0] r;
  } res_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] sh;
    res_t       exp;
  } vec_t;

  typedef struct {
    res_t exp;
    int   age;
  } item_t;

  // ALU behaviour; undefined opcodes return junk so forced-zero capture is visible.
  function automatic res_t alu_model(input logic [3:0] op, input logic [7:0] a,
                                     input logic [7:0] b, input logic [4:0] sh);
    res_t        t;
    logic [8:0]  sum;
    logic [15:0] rot;
    t = '0;
    case (op)
      4'd0: begin
        sum = {1'b0, a} + {1'b0, b};
        t.r = sum[7:0];
        t.c = sum[8];
        t.v = (a[7] == b[7]) && (t.r[7] != a[7]);
      end
      4'd1: begin
        t.r = a - b;
        t.c = (a < b);
        t.v = (a[7] != b[7]) && (t.r[7] != a[7]);
      end
      4'd2: t.r = a & b;
      4'd3: t.r = a | b;
      4'd4: begin
        rot = {a, a} << (sh % 8);
        t.r = rot[15:8];
      end
      4'd5: t.r = (a == b) ? 8'd1 : 8'd0;
      default: begin
        t.r = a | 8'h01;
        t.c = 1'b1;
        t.v = 1'b1;
      end
    endcase
    t.z = (t.r == 8'd0);
    return t;
  endfunction

  function automatic res_t exp_packet(input logic [3:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [4:0] sh);
    res_t t;
    if (op > 4'(MAX_OP)) begin
      t     = '0;
      t.ill = 1'b1;
    end else begin
      t = alu_model(op, a, b, sh);
    end
    return t;
  endfunction

  res_t alu_out;
  assign alu_out      = alu_model(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
  assign alu_result   = alu_out.r;
  assign alu_carry    = alu_out.c;
  assign alu_zero     = alu_out.z;
  assign alu_overflow = alu_out.v;

  int          checks = 0;
  int          errors = 0;
  item_t       q[$];
  logic [15:0] op_cnt_exp;
  logic [7:0]  ill_exp;
  res_t        next_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare DUT against the model, cross the edge, advance the model.
  task automatic tick(output bit acc);
    bit          vis;
    bit          exp_ready;
    bit          comp;
    bit          ill;
    logic [24:0] pkt;
    #2;
    vis       = (q.size() > 0) && (q[0].age >= 2);
    exp_ready = !flush && ((q.size() < 2) || bus.out_ready);
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("out_valid", 32'(bus.out_valid), 32'(vis));
    if (vis) begin
      check("out_packet", 32'({bus.out_illegal, bus.out_carry, bus.out_zero,
                               bus.out_overflow, bus.out_result}), 32'(q[0].exp));
    end
    check("op_count", 32'(op_count), 32'(op_cnt_exp));
    check("illegal_count", 32'(illegal_count), 32'(ill_exp));
    comp = vis && bus.out_ready;
    acc  = bus.in_valid && exp_ready;
    pkt  = {bus.in_opcode, bus.in_a, bus.in_b, bus.in_shift};
    @(posedge clk);
    if (comp) begin
      ill = q[0].exp.ill;
      void'(q.pop_front());
      op_cnt_exp++;
      if (ill && (ill_exp != 8'hFF)) ill_exp++;
    end
    if (flush) begin
      q.delete();
    end else begin
      foreach (q[i]) q[i].age++;
      if (acc) q.push_back('{exp: next_exp, age: 1});
    end
    #1;
    if (acc) check("alu_inputs", 32'({alu_opcode, alu_input1, alu_input2, alu_shiftValue}), 32'(pkt));
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [4:0] sh, input res_t e);
    bit acc;
    acc           = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_shift  = sh;
    next_exp      = e;
    for (int n = 0; n < 20 && !acc; n++) tick(acc);
    check("send_accepted", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  vec_t        vecs[8];
  bit          acc;
  logic [15:0] cnt_snap;
  logic [3:0]  rop;
  logic [7:0]  ra;
  logic [7:0]  rb;
  logic [4:0]  rsh;

  initial begin
    vecs[0] = '{4'd0, 8'h7F, 8'h01, 5'd0, '{1'b0, 1'b0, 1'b0, 1'b1, 8'h80}};
    vecs[1] = '{4'd1, 8'h05, 8'h05, 5'd0, '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00}};
    vecs[2] = '{4'd2, 8'hF0, 8'h0F, 5'd0, '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00}};
    vecs[3] = '{4'd3, 8'h00, 8'h00, 5'd0, '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00}};
    vecs[4] = '{4'd0, 8'hFF, 8'h01, 5'd0, '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00}};
    vecs[5] = '{4'd5, 8'h3C, 8'h3C, 5'd0, '{1'b0, 1'b0, 1'b0, 1'b0, 8'h01}};
    vecs[6] = '{4'd4, 8'h81, 8'h00, 5'd1, '{1'b0, 1'b0, 1'b0, 1'b0, 8'h03}};
    vecs[7] = '{4'd9, 8'hAA, 8'h55, 5'd0, '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00}};

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_a = '0; bus.in_b = '0; bus.in_shift = '0;
    bus.out_ready = 1'b0;
    op_cnt_exp = '0; ill_exp = '0; next_exp = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_alu", 32'({alu_opcode, alu_input1, alu_input2, alu_shiftValue}), 32'd0);
    check("rst_counters", 32'({op_count, illegal_count}), 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors back-to-back at full throughput.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].exp);
    idle(4);
    check("table_op_count", 32'(op_count), 32'd8);
    check("table_illegal_count", 32'(illegal_count), 32'd1);

    // Stall: two packets fill the pipe, a third waits until the consumer releases.
    bus.out_ready = 1'b0;
    send(4'd0, 8'h10, 8'h20, 5'd0, exp_packet(4'd0, 8'h10, 8'h20, 5'd0));
    send(4'd1, 8'h30, 8'h01, 5'd0, exp_packet(4'd1, 8'h30, 8'h01, 5'd0));
    bus.in_valid = 1'b1; bus.in_opcode = 4'd3; bus.in_a = 8'h0C; bus.in_b = 8'hA0; bus.in_shift = '0;
    next_exp = exp_packet(4'd3, 8'h0C, 8'hA0, 5'd0);
    for (int i = 0; i < 3; i++) tick(acc);
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) tick(acc);
    bus.in_valid = 1'b0;
    idle(4);
    check("stall_op_count", 32'(op_count), 32'd11);

    // Illegal saturation: 256 further illegal packets.
    for (int i = 0; i < 256; i++) send(4'd9 + 4'(i % 7), 8'(i), 8'hAA, 5'd0, exp_packet(4'd9, 8'h00, 8'h00, 5'd0));
    idle(4);
    check("illegal_saturated", 32'(illegal_count), 32'd255);

    // Flush with both stages full.
    bus.out_ready = 1'b0;
    send(4'd0, 8'h01, 8'h02, 5'd0, exp_packet(4'd0, 8'h01, 8'h02, 5'd0));
    send(4'd2, 8'hFF, 8'h3C, 5'd0, exp_packet(4'd2, 8'hFF, 8'h3C, 5'd0));
    cnt_snap = op_count;
    flush = 1'b1;
    tick(acc);
    flush = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    idle(2);
    check("flush_op_count", 32'(op_count), 32'(cnt_snap));
    send(4'd4, 8'h81, 8'h00, 5'd1, '{1'b0, 1'b0, 1'b0, 1'b0, 8'h03});
    idle(3);

    // Randomized traffic with stalls and occasional flushes.
    for (int i = 0; i < 2000; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      ra = 8'($urandom); rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom); rsh = 5'($urandom);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_opcode = rop; bus.in_a = ra; bus.in_b = rb; bus.in_shift = rsh;
      next_exp = exp_packet(rop, ra, rb, rsh);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      tick(acc);
    end
    bus.in_valid = 1'b0; flush = 1'b0; bus.out_ready = 1'b1;
    idle(4);

    // Completion counter wrap.
    bus.in_valid = 1'b1; bus.in_opcode = 4'd0; bus.in_a = 8'h11; bus.in_b = 8'h22; bus.in_shift = '0;
    next_exp = exp_packet(4'd0, 8'h11, 8'h22, 5'd0);
    for (int n = 0; n < 70000 && op_cnt_exp != 16'hFFFF; n++) tick(acc);
    check("op_count_max", 32'(op_count), 32'hFFFF);
    for (int n = 0; n < 5 && op_cnt_exp != 16'h0000; n++) tick(acc);
    check("op_count_wrap", 32'(op_count), 32'd0);

    // Asynchronous reset in the middle of a stall.
    bus.out_ready = 1'b0;
    idle(3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd0);
    check("arst_out_packet", 32'({bus.out_illegal, bus.out_carry, bus.out_zero,
                                  bus.out_overflow, bus.out_result}), 32'd0);
    check("arst_alu", 32'({alu_opcode, alu_input1, alu_input2, alu_shiftValue}), 32'd0);
    check("arst_counters", 32'({op_count, illegal_count}), 32'd0);
    q.delete(); op_cnt_exp = '0; ill_exp = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
